icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage and mem_control.
- On a hit it returns the instruction one cycle after the request.
- On a miss it raises a request to mem_control (inst_needed / inst_addr_i), waits for inst_available, fills the line and forwards the word to IF.
- A branch flush aborts an outstanding fetch; the same flush signal drives mem_control's branch_interception.

Parameters:
- INDEX_BITS, 7: line index width; the cache has 2^INDEX_BITS lines of 32 bits each.
- ADDR_WIDTH, 32: instruction address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  branch redirect from IF/EX; aborts any in-flight fetch.
- if_req  input  1  IF requests the instruction at if_addr; held high until if_valid.
- if_addr  input  ADDR_WIDTH  fetch PC; bits [1:0] are ignored.
- if_inst  output  32  returned instruction; valid when if_valid=1 and held until the next if_valid.
- if_valid  output  1  one-cycle pulse marking if_inst valid for the current request.
- mem_req  output  1  connects to mem_control inst_needed.
- mem_addr  output  ADDR_WIDTH  connects to mem_control inst_addr_i; word-aligned, bits [1:0]=0.
- mem_inst  input  32  connects to mem_control inst.
- mem_valid  input  1  connects to mem_control inst_available; one-cycle pulse.

Behaviour:
Address fields:
- index = addr[INDEX_BITS+1:2].
- tag = addr[ADDR_WIDTH-1:INDEX_BITS+2].
- Per-line storage is a valid bit, a tag and a 32-bit data word, all held in registers.

Reset (asynchronous, any state, including mid-miss):
- All valid bits cleared; state=IDLE.
- mem_req=0, mem_addr=0, if_valid=0, if_inst=0.
- A mem_valid arriving after reset is ignored.

States:
- IDLE
  - If if_req=1 and flush=0, look up if_addr combinationally.
  - Hit (valid and tag equal): next edge sets if_inst=data and if_valid=1; stay in IDLE.
  - Miss: next edge latches the aligned address into mem_addr, sets mem_req=1 and goes to MISS; if_valid=0.
  - if_req=0: if_valid=0.
  - mem_valid seen in IDLE is stale and ignored: no fill, no response.
- MISS
  - Hold mem_req=1 and a stable mem_addr until mem_valid=1.
  - On mem_valid with flush=0, at the next edge:
    - write the line: valid=1, tag from mem_addr, data=mem_inst;
    - if_inst=mem_inst, if_valid=1;
    - mem_req=0; return to IDLE.
  - if_req/if_addr changes while in MISS are ignored. IF must hold its request, so a new address can only follow a flush.

Flush (highest priority after reset):
- From any state, next edge: state=IDLE, mem_req=0, if_valid=0.
- flush and mem_valid in the same cycle: the line is still written (the data matches mem_addr), but if_valid stays 0.
- flush and if_req in the same cycle: no lookup. IF re-presents the redirected PC the following cycle.

Timing and handshake:
- if_valid is never high for two consecutive cycles within one request. After each if_valid, IF either drops if_req or presents the next PC.
- Hit latency: 1 cycle from if_req to if_valid.
- Miss latency: mem_control latency + 1 cycle.
- Back-to-back hits sustain one instruction per cycle. A new if_addr is sampled in the same cycle that if_valid is high.
- mem_req drops on the same edge that if_valid rises, so mem_control sees inst_needed=0 in its next idle cycle.

Conflicts and write-back:
- Lines whose addresses share an index overwrite each other; there is no replacement policy beyond overwrite.
- There is no write-back and no snoop path. Self-modifying code is not supported.

Test Plan:
- Cold miss: reset, then if_req with if_addr=0x00000000; mem_valid after 6 cycles with mem_inst=0x00000013. Required: mem_req=1 and mem_addr=0x0 during the wait; if_valid=1 and if_inst=0x00000013 exactly one cycle after mem_valid; mem_req=0 in that same cycle.
- Hit: after the cold-miss fill, request 0x00000000 again. Required: if_valid one cycle after if_req with if_inst=0x00000013; mem_req never asserted.
- Conflict eviction (INDEX_BITS=7): fill 0x00000004, then request 0x00000204 (same index, different tag). Required: a miss with mem_addr=0x204. A subsequent request for 0x004 misses again.
- Flush during miss: request 0x100, then assert flush 2 cycles later. Required: mem_req=0 next cycle, no if_valid. A later mem_valid pulse in IDLE causes no fill; re-requesting 0x100 misses.
- Flush coincident with mem_valid for 0x80 (mem_inst=0xDEADBEEF). Required: if_valid stays 0. A following request for 0x80 hits, returning 0xDEADBEEF in 1 cycle.
- Reset mid-miss: assert rst asynchronously (between clock edges) while in MISS. Required: mem_req=0 and if_valid=0 immediately, without waiting for a clock edge; all lines invalid; the next request to a previously filled address misses.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the IF stage and mem_control.
// A hit answers one cycle after the request; a miss fetches the word, fills the line and forwards it.
//
// state   | meaning
// ST_IDLE | look up if_addr on each request; answer hits, launch misses
// ST_MISS | mem_req held with a stable mem_addr until mem_valid returns the word
module icache_direct #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_inst,
  output logic                  if_valid,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_inst,
  input  logic                  mem_valid
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_MISS = 1'b1;

  logic                  state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  if_valid_q, if_valid_d;
  logic [31:0]           if_inst_q, if_inst_d;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [INDEX_BITS-1:0] lk_idx, fill_idx;
  logic [TAG_W-1:0]      lk_tag, fill_tag;
  logic                  hit;
  logic                  fill_en;
  logic                  unused_addr_bits;

  assign lk_idx   = if_addr[INDEX_BITS+1:2];
  assign lk_tag   = if_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
  assign unused_addr_bits = ^if_addr[1:0];

  assign hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  // The returning word always belongs to mem_addr, so it is written even under flush.
  assign fill_en = (state_q == ST_MISS) && mem_valid;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if_valid_d = 1'b0;
    if_inst_d  = if_inst_q;
    if (flush) begin
      state_d   = ST_IDLE;
      mem_req_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (if_req) begin
            if (hit) begin
              if_inst_d  = data_q[lk_idx];
              if_valid_d = 1'b1;
            end else begin
              mem_addr_d = {if_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_req_d  = 1'b1;
              state_d    = ST_MISS;
            end
          end
        end
        ST_MISS: begin
          if (mem_valid) begin
            if_inst_d  = mem_inst;
            if_valid_d = 1'b1;
            mem_req_d  = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only read when its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_inst;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized fetches
// checked against an index-keyed model of lines and a fixed backing-memory pattern.
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;
  logic        mem_valid;

  int n_tests = 0;
  int n_fail  = 0;

  icache_direct #(.INDEX_BITS(7), .ADDR_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_inst  (if_inst),
    .if_valid (if_valid),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_inst (mem_inst),
    .mem_valid(mem_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: 128 lines, each remembering the full aligned address it holds and its word.
  bit          m_valid [int];
  logic [31:0] m_addr  [int];
  logic [31:0] m_data  [int];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 128);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int i = idx_of(a);
    return m_valid.exists(i) && m_valid[i] && (m_addr[i] == (a & ~32'h3));
  endfunction

  function automatic void m_fill(input logic [31:0] a, input logic [31:0] d);
    int i = idx_of(a);
    m_valid[i] = 1'b1;
    m_addr[i]  = a & ~32'h3;
    m_data[i]  = d;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // One IF request starting at a negedge; serves a miss after lat cycles. Ends at a negedge, if_req low.
  task automatic fetch(input logic [31:0] a, input int lat, input logic [31:0] d,
                       output bit miss, output bit resp, output logic [31:0] maddr,
                       output logic [31:0] inst, output bit stable, output bit req_drop);
    miss = 0; resp = 0; maddr = '0; inst = '0; stable = 1; req_drop = 1;
    if_req  = 1'b1;
    if_addr = a;
    @(negedge clk);
    if (if_valid) begin
      resp = 1;
      inst = if_inst;
    end else if (mem_req) begin
      miss  = 1;
      maddr = mem_addr;
      for (int k = 1; k < lat; k++) begin
        if_addr = $urandom;
        @(negedge clk);
        if (!mem_req || mem_addr !== maddr || if_valid) stable = 0;
      end
      mem_valid = 1'b1;
      mem_inst  = d;
      @(negedge clk);
      mem_valid = 1'b0;
      resp      = if_valid;
      inst      = if_inst;
      req_drop  = !mem_req;
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
    n_tests++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL reset_if_inst got=%h exp=0", if_inst); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    bit miss, resp, stable, drop; logic [31:0] maddr, inst;
    fetch(32'h0, 6, 32'h0000_0013, miss, resp, maddr, inst, stable, drop);
    m_fill(32'h0, 32'h0000_0013);
    n_tests++; if (miss !== 1'b1) begin n_fail++; $display("FAIL cold_miss_detect got=%b exp=1", miss); end
    n_tests++; if (maddr !== 32'h0) begin n_fail++; $display("FAIL cold_mem_addr got=%h exp=0", maddr); end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL cold_wait_stable got=%b exp=1", stable); end
    n_tests++; if (resp !== 1'b1) begin n_fail++; $display("FAIL cold_if_valid got=%b exp=1", resp); end
    n_tests++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL cold_if_inst got=%h exp=00000013", inst); end
    n_tests++; if (drop !== 1'b1) begin n_fail++; $display("FAIL cold_mem_req_drop got=%b exp=1", drop); end
    @(negedge clk);
    n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL cold_if_valid_pulse got=%b exp=0", if_valid); end
  endtask

  task automatic test_hit();
    bit miss, resp, stable, drop; logic [31:0] maddr, inst;
    fetch(32'h0, 1, 32'hFFFF_FFFF, miss, resp, maddr, inst, stable, drop);
    n_tests++; if (miss !== 1'b0 || resp !== 1'b1) begin n_fail++; $display("FAIL hit_latency got miss=%b resp=%b exp miss=0 resp=1", miss, resp); end
    n_tests++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL hit_if_inst got=%h exp=00000013", inst); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_mem_req got=%b exp=0", mem_req); end
    @(negedge clk);
  endtask

  task automatic test_conflict();
    bit miss, resp, stable, drop; logic [31:0] maddr, inst;
    fetch(32'h4, 3, mem_word(32'h4), miss, resp, maddr, inst, stable, drop);
    m_fill(32'h4, mem_word(32'h4));
    n_tests++; if (miss !== 1'b1 || inst !== mem_word(32'h4)) begin n_fail++; $display("FAIL conflict_first_fill got miss=%b inst=%h exp miss=1 inst=%h", miss, inst, mem_word(32'h4)); end
    fetch(32'h204, 2, mem_word(32'h204), miss, resp, maddr, inst, stable, drop);
    m_fill(32'h204, mem_word(32'h204));
    n_tests++; if (miss !== 1'b1 || maddr !== 32'h204) begin n_fail++; $display("FAIL conflict_evict got miss=%b addr=%h exp miss=1 addr=00000204", miss, maddr); end
    n_tests++; if (inst !== mem_word(32'h204)) begin n_fail++; $display("FAIL conflict_evict_inst got=%h exp=%h", inst, mem_word(32'h204)); end
    fetch(32'h4, 2, mem_word(32'h4), miss, resp, maddr, inst, stable, drop);
    n_tests++; if (miss !== !m_hit(32'h4) || maddr !== 32'h4) begin n_fail++; $display("FAIL conflict_remiss got miss=%b addr=%h exp miss=1 addr=00000004", miss, maddr); end
    m_fill(32'h4, mem_word(32'h4));
  endtask

  task automatic test_flush_miss();
    bit miss, resp, stable, drop; logic [31:0] maddr, inst;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL flush_miss_launch got req=%b addr=%h exp req=1 addr=00000100", mem_req, mem_addr); end
    @(negedge clk);
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    n_tests++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_miss_abort got req=%b valid=%b exp 0 0", mem_req, if_valid); end
    mem_valid = 1'b1; mem_inst = 32'h1111_1111;
    @(negedge clk);
    mem_valid = 1'b0;
    n_tests++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_stale_valid got valid=%b req=%b exp 0 0", if_valid, mem_req); end
    fetch(32'h100, 2, mem_word(32'h100), miss, resp, maddr, inst, stable, drop);
    n_tests++; if (miss !== 1'b1 || maddr !== 32'h100) begin n_fail++; $display("FAIL flush_rerequest got miss=%b addr=%h exp miss=1 addr=00000100", miss, maddr); end
    n_tests++; if (inst !== mem_word(32'h100)) begin n_fail++; $display("FAIL flush_rerequest_inst got=%h exp=%h", inst, mem_word(32'h100)); end
    m_fill(32'h100, mem_word(32'h100));
  endtask

  task automatic test_flush_fill();
    bit miss, resp, stable, drop; logic [31:0] maddr, inst;
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin n_fail++; $display("FAIL flush_fill_launch got req=%b addr=%h exp req=1 addr=00000080", mem_req, mem_addr); end
    @(negedge clk);
    flush = 1'b1; mem_valid = 1'b1; mem_inst = 32'hDEAD_BEEF; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0; mem_valid = 1'b0;
    m_fill(32'h80, 32'hDEAD_BEEF);
    n_tests++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_fill_no_valid got valid=%b req=%b exp 0 0", if_valid, mem_req); end
    fetch(32'h80, 1, 32'h0, miss, resp, maddr, inst, stable, drop);
    n_tests++; if (miss !== 1'b0 || resp !== 1'b1) begin n_fail++; $display("FAIL flush_fill_hit got miss=%b resp=%b exp miss=0 resp=1", miss, resp); end
    n_tests++; if (inst !== m_data[idx_of(32'h80)]) begin n_fail++; $display("FAIL flush_fill_data got=%h exp=deadbeef", inst); end
  endtask

  task automatic test_back_to_back();
    bit miss, resp, stable, drop; logic [31:0] maddr, inst;
    logic [31:0] addrs [4];
    for (int i = 0; i < 4; i++) begin
      addrs[i] = 32'h400 + 32'(i * 4);
      fetch(addrs[i], 2, mem_word(addrs[i]), miss, resp, maddr, inst, stable, drop);
      m_fill(addrs[i], mem_word(addrs[i]));
    end
    if_req = 1'b1; if_addr = addrs[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if (if_valid !== 1'b1 || if_inst !== mem_word(addrs[i])) begin n_fail++; $display("FAIL b2b_hit_%0d got valid=%b inst=%h exp valid=1 inst=%h", i, if_valid, if_inst, mem_word(addrs[i])); end
      if (i < 3) if_addr = addrs[i+1];
      else if_req = 1'b0;
    end
    @(negedge clk);
    n_tests++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got valid=%b req=%b exp 0 0", if_valid, mem_req); end
  endtask

  task automatic test_random();
    bit miss, resp, stable, drop, exp_hit; logic [31:0] maddr, inst, a, al, exp_inst;
    int idx_pool [6] = '{5, 6, 7, 8, 9, 127};
    logic [31:0] tag_pool [3] = '{32'h0, 32'h1, 32'h7FFFF};
    for (int n = 0; n < 60; n++) begin
      a  = (tag_pool[$urandom_range(0, 2)] << 9) | (32'(idx_pool[$urandom_range(0, 5)]) << 2) | 32'($urandom_range(0, 3));
      al = a & ~32'h3;
      exp_hit  = m_hit(a);
      exp_inst = exp_hit ? m_data[idx_of(a)] : mem_word(al);
      fetch(a, $urandom_range(1, 5), mem_word(al), miss, resp, maddr, inst, stable, drop);
      n_tests++; if (miss !== !exp_hit || resp !== 1'b1 || inst !== exp_inst) begin n_fail++; $display("FAIL rand_%0d addr=%h got miss=%b resp=%b inst=%h exp miss=%b resp=1 inst=%h", n, a, miss, resp, inst, !exp_hit, exp_inst); end
      if (!exp_hit) begin
        n_tests++; if (maddr !== al || stable !== 1'b1 || drop !== 1'b1) begin n_fail++; $display("FAIL rand_miss_%0d got addr=%h stable=%b drop=%b exp addr=%h 1 1", n, maddr, stable, drop, al); end
        m_fill(a, mem_word(al));
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_miss();
    bit miss, resp, stable, drop; logic [31:0] maddr, inst;
    fetch(32'h40, 2, 32'h4040_4040, miss, resp, maddr, inst, stable, drop);
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_launch got req=%b exp 1", mem_req); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_outputs got req=%b valid=%b exp 0 0", mem_req, if_valid); end
    n_tests++; if (if_inst !== 32'h0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_async_regs got inst=%h addr=%h exp 0 0", if_inst, mem_addr); end
    @(negedge clk);
    if_req = 1'b0; rst = 1'b0;
    m_valid.delete();
    @(negedge clk);
    mem_valid = 1'b1; mem_inst = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_valid = 1'b0;
    n_tests++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_stale_valid got valid=%b req=%b exp 0 0", if_valid, mem_req); end
    fetch(32'h40, 2, 32'h4040_4040, miss, resp, maddr, inst, stable, drop);
    n_tests++; if (miss !== !m_hit(32'h40) || maddr !== 32'h40) begin n_fail++; $display("FAIL rst_lines_invalid got miss=%b addr=%h exp miss=1 addr=00000040", miss, maddr); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = '0; mem_inst = '0; mem_valid = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_miss();
    test_flush_fill();
    test_back_to_back();
    test_random();
    test_reset_mid_miss();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
